// File: rtl/fir_out_buffer.sv
// Output buffer behind the FIR filter: rescales the 18-bit result to 16 bits (round-half-up,
// saturating) and queues it in a first-word-fall-through FIFO. Optional peak tracker: FIR_OUT_PEAK_EN.
module fir_out_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned SHIFT = 2,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [17:0]   in_data,
  input  logic          in_valid,
  output logic [15:0]   out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
`ifdef FIR_OUT_PEAK_EN
  output logic [15:0]   peak,
`endif
  output logic          sat
);

  localparam int unsigned LW = AW + 1;
  localparam logic [18:0] RndAdd = (SHIFT > 0) ? (19'd1 << (SHIFT - 1)) : 19'd0;

  typedef logic [AW-1:0] ptr_t;

  logic [18:0]   rnd;
  logic [18:0]   scaled;
  logic          clip;
  logic          full_w;
  logic          push_acc;
  logic          pop_acc;

  logic [15:0]   s1_data_d, s1_data_q;
  logic          s1_valid_d, s1_valid_q;
  ptr_t          wr_ptr_d, wr_ptr_q;
  ptr_t          rd_ptr_d, rd_ptr_q;
  logic [LW-1:0] level_d, level_q;
  logic          overflow_d, overflow_q;
  logic          sat_d, sat_q;
`ifdef FIR_OUT_PEAK_EN
  logic [15:0]   peak_d, peak_q;
`endif

  logic [15:0]   mem_q [DEPTH];

  always_comb begin
    rnd      = {1'b0, in_data} + RndAdd;
    scaled   = rnd >> SHIFT;
    clip     = |scaled[18:16];
    full_w   = (level_q == LW'(DEPTH));
    pop_acc  = (level_q != '0) && out_ready;
    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    push_acc = s1_valid_q && (!full_w || pop_acc);
  end

  always_comb begin
    s1_valid_d = in_valid;
    s1_data_d  = s1_data_q;
    if (in_valid) begin
      s1_data_d = clip ? 16'hFFFF : scaled[15:0];
    end
    sat_d      = sat_q | (in_valid & clip);
    wr_ptr_d   = wr_ptr_q + ptr_t'(push_acc);
    rd_ptr_d   = rd_ptr_q + ptr_t'(pop_acc);
    level_d    = level_q + LW'(push_acc) - LW'(pop_acc);
    overflow_d = overflow_q | (s1_valid_q & ~push_acc);
`ifdef FIR_OUT_PEAK_EN
    peak_d     = peak_q;
    if (push_acc && (s1_data_q > peak_q)) begin
      peak_d = s1_data_q;
    end
`endif
    if (clr) begin
      s1_valid_d = 1'b0;
      sat_d      = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      overflow_d = 1'b0;
`ifdef FIR_OUT_PEAK_EN
      peak_d     = '0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_data_q  <= '0;
      s1_valid_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      sat_q      <= 1'b0;
`ifdef FIR_OUT_PEAK_EN
      peak_q     <= '0;
`endif
    end else begin
      s1_data_q  <= s1_data_d;
      s1_valid_q <= s1_valid_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      sat_q      <= sat_d;
`ifdef FIR_OUT_PEAK_EN
      peak_q     <= peak_d;
`endif
    end
  end

  // Storage is not reset; level gates every read of it.
  always_ff @(posedge clk) begin
    if (push_acc && !clr) begin
      mem_q[wr_ptr_q] <= s1_data_q;
    end
  end

  always_comb begin
    out_valid = (level_q != '0);
    out_data  = out_valid ? mem_q[rd_ptr_q] : 16'd0;
    level     = level_q;
    full      = full_w;
    overflow  = overflow_q;
    sat       = sat_q;
`ifdef FIR_OUT_PEAK_EN
    peak      = peak_q;
`endif
  end

endmodule

// File: tb/tb_fir_out_buffer.sv
// Directed bench for fir_out_buffer at DEPTH=8, SHIFT=2; peak checks built when FIR_OUT_PEAK_EN is set.
module tb_fir_out_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [17:0] in_data;
  logic        in_valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  level;
  logic        full;
  logic        overflow;
  logic        sat;
`ifdef FIR_OUT_PEAK_EN
  logic [15:0] peak;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fir_out_buffer #(.DEPTH(8), .SHIFT(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level    (level),
    .full     (full),
    .overflow (overflow),
`ifdef FIR_OUT_PEAK_EN
    .peak     (peak),
`endif
    .sat      (sat)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_sat", 32'(sat), 0);
    chk("rst_data", 32'(out_data), 0);
`ifdef FIR_OUT_PEAK_EN
    chk("rst_peak", 32'(peak), 0);
`endif
    #10 rst_n = 1'b1;
    step();

    // Rounding: (10+2)>>2 = 3, visible two edges after the strobe.
    in_data = 18'd10; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("lat_not_yet", 32'(out_valid), 0);
    step();
    chk("lat_valid", 32'(out_valid), 1);
    chk("rnd_data", 32'(out_data), 3);
    chk("rnd_level", 32'(level), 1);
    chk("rnd_sat", 32'(sat), 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_level", 32'(level), 0);
    chk("pop_data", 32'(out_data), 0);
    chk("pop_valid", 32'(out_valid), 0);

    // Saturation then round-half boundary: 5 -> 1, 6 -> 2.
    in_data = 18'h3FFFF; in_valid = 1'b1;
    step();
    chk("sat_set", 32'(sat), 1);
    in_data = 18'd5;
    step();
    chk("sat_data", 32'(out_data), 32'hFFFF);
    in_data = 18'd6;
    step();
    in_valid = 1'b0;
    step();
    chk("sat_level", 32'(level), 3);
    chk("sat_sticky", 32'(sat), 1);
    out_ready = 1'b1;
    step();
    chk("rnd_half_lo", 32'(out_data), 1);
    step();
    chk("rnd_half_hi", 32'(out_data), 2);
    step();
    out_ready = 1'b0;
    chk("sat_drain", 32'(level), 0);
    chk("sat_sticky2", 32'(sat), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_sat", 32'(sat), 0);

    // Fill and overflow: 10 samples into 8 entries.
    for (int i = 1; i <= 10; i++) begin
      in_data = 18'(4 * i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    chk("fill_level", 32'(level), 8);
    chk("fill_full", 32'(full), 1);
    chk("fill_ovf", 32'(overflow), 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("drain_%0d", i), 32'(out_data), 32'(i));
      step();
    end
    out_ready = 1'b0;
    chk("drain_level", 32'(level), 0);
    chk("drain_full", 32'(full), 0);
    chk("ovf_sticky", 32'(overflow), 1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_ovf", 32'(overflow), 0);

    // Full with simultaneous pop and continuous input.
    for (int i = 1; i <= 9; i++) begin
      in_data = 18'(4 * i); in_valid = 1'b1;
      step();
    end
    chk("fp_level0", 32'(level), 8);
    chk("fp_full0", 32'(full), 1);
    out_ready = 1'b1;
    for (int i = 10; i <= 15; i++) begin
      in_data = 18'(4 * i);
      chk($sformatf("fp_head_%0d", i - 9), 32'(out_data), 32'(i - 9));
      step();
      chk($sformatf("fp_level_%0d", i), 32'(level), 8);
      chk($sformatf("fp_ovf_%0d", i), 32'(overflow), 0);
    end
    in_valid = 1'b0;
    for (int k = 7; k <= 15; k++) begin
      chk($sformatf("fp_drain_%0d", k), 32'(out_data), 32'(k));
      step();
    end
    out_ready = 1'b0;
    chk("fp_empty", 32'(level), 0);
    chk("fp_ovf_end", 32'(overflow), 0);

    // clr mid-stream with a concurrent (saturating) sample.
    for (int i = 1; i <= 6; i++) begin
      in_data = 18'(4 * i); in_valid = 1'b1;
      step();
    end
    chk("clr_pre_level", 32'(level), 5);
    in_data = 18'h3FFFF; clr = 1'b1;
    step();
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_level", 32'(level), 0);
    chk("clr_valid", 32'(out_valid), 0);
    chk("clr_ovf2", 32'(overflow), 0);
    chk("clr_sat2", 32'(sat), 0);
    step();
    step();
    chk("clr_no_emit", 32'(out_valid), 0);
    chk("clr_no_level", 32'(level), 0);

    // Asynchronous reset between edges.
    for (int i = 1; i <= 3; i++) begin
      in_data = 18'(4 * i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("ar_pre_level", 32'(level), 3);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_level", 32'(level), 0);
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_data", 32'(out_data), 0);
`ifdef FIR_OUT_PEAK_EN
    chk("ar_peak", 32'(peak), 0);
`endif
    #2 rst_n = 1'b1;
    step();
    step();
    chk("ar_no_emit", 32'(out_valid), 0);

`ifdef FIR_OUT_PEAK_EN
    // Post-scale 5, 200, 7.
    in_data = 18'd20; in_valid = 1'b1;
    step();
    in_data = 18'd800;
    step();
    in_data = 18'd28;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("peak_val", 32'(peak), 200);
    chk("peak_level", 32'(level), 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
